// File: rtl/alu_ctrl_pkg.sv
// ALU control code definitions shared with the ALU control decoder, plus the
// state encoding for the bit-serial execution unit.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0000;
  localparam logic [3:0] ALU_NOR = 4'b1101;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Subtract-style codes feed ~B with a carry-in of 1 (two's complement).
  function automatic logic inverts_b(input logic [3:0] ctrl);
    return (ctrl == ALU_SUB) || (ctrl == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice.
//   a, b        : operand slices (b is the original, uninverted operand)
//   b_inv       : invert b before the adder (sub/slt)
//   cin         : carry in from the previous slice
//   ctrl        : ALU control code
//   y           : slice result
//   cout        : carry out of the slice's top bit
//   c_into_msb  : carry into the slice's top bit (overflow detection)
module alu_slice
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             b_inv,
  input  logic             cin,
  input  logic [3:0]       ctrl,
  output logic [SLICE-1:0] y,
  output logic             cout,
  output logic             c_into_msb
);

  logic [SLICE-1:0] bx;
  logic [SLICE:0]   sum;

  always_comb begin
    bx         = b ^ {SLICE{b_inv}};
    sum        = {1'b0, a} + {1'b0, bx} + {{SLICE{1'b0}}, cin};
    cout       = sum[SLICE];
    // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly.
    c_into_msb = a[SLICE-1] ^ bx[SLICE-1] ^ sum[SLICE-1];
    case (ctrl)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOR: y = ~(a | b);
      default: y = sum[SLICE-1:0];
    endcase
  end

endmodule

// File: rtl/alu_slice_exec.sv
// Bit-serial ALU execution unit: accepts one operation over a valid/ready
// handshake, evaluates it SLICE bits per cycle (LSB slice first) and returns
// result plus zero/overflow/illegal flags over a second valid/ready handshake.
//   clk_i, rst_i              : clock, async active-high reset
//   in_valid_i / in_ready_o   : request handshake
//   alu_ctrl_i, src1_i, src2_i: request payload
//   out_valid_o / out_ready_i : response handshake
//   result_o, zero_o, overflow_o, illegal_o : response payload
module alu_slice_exec
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             illegal_o
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [3:0]       ctrl_q;
  logic             binv_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, ovf_q, illegal_q, in_ready_q, out_valid_q;

  logic [SLICE-1:0] a_sl, b_sl, y_sl;
  logic             cout_sl, cmsb_sl;
  logic [WIDTH-1:0] acc_d, result_d;
  logic             zero_d, ovf_d, illegal_d, add_ovf;

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a          (a_sl),
    .b          (b_sl),
    .b_inv      (binv_q),
    .cin        (carry_q),
    .ctrl       (ctrl_q),
    .y          (y_sl),
    .cout       (cout_sl),
    .c_into_msb (cmsb_sl)
  );

  // Working value with the current slice merged in; on the last slice this is
  // the full raw result, so finalisation happens on the same edge as RUN->DONE.
  always_comb begin
    a_sl  = a_q[cnt_q*SLICE +: SLICE];
    b_sl  = b_q[cnt_q*SLICE +: SLICE];
    acc_d = acc_q;
    acc_d[cnt_q*SLICE +: SLICE] = y_sl;
    add_ovf   = cmsb_sl ^ cout_sl;
    result_d  = acc_d;
    ovf_d     = 1'b0;
    illegal_d = 1'b0;
    case (ctrl_q)
      ALU_ADD, ALU_SUB: ovf_d = add_ovf;
      ALU_SLT: begin
        result_d    = '0;
        result_d[0] = acc_d[WIDTH-1] ^ add_ovf;
      end
      ALU_AND, ALU_OR, ALU_NOR: ;
      default: begin
        result_d  = '0;
        illegal_d = 1'b1;
      end
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      ctrl_q      <= '0;
      binv_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            a_q        <= src1_i;
            b_q        <= src2_i;
            ctrl_q     <= alu_ctrl_i;
            binv_q     <= inverts_b(alu_ctrl_i);
            carry_q    <= inverts_b(alu_ctrl_i);
            cnt_q      <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= cout_sl;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign overflow_o  = ovf_q;
  assign illegal_o   = illegal_q;

endmodule

// File: doc/alu_slice_exec.md
Name: alu_slice_exec

Overview:
- Execution-side responder for the 4-bit ALU control code produced by the ALU control decoder.
- Accepts one operation (ALU control code plus two operands) through a valid/ready handshake.
- Evaluates the operation bit-serially, SLICE bits per cycle, LSB slice first.
- Returns the result, zero and overflow flags through a second valid/ready handshake.
- Sits between the ID/EX operand latch and the EX/MEM write-back latch, for multi-cycle-EX experiments.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 8, bits processed per RUN cycle; NSLICE = WIDTH/SLICE.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  block can accept a request.
- alu_ctrl_i  in  4  ALU control code.
- src1_i  in  WIDTH  operand A.
- src2_i  in  WIDTH  operand B.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer takes the result.
- result_o  out  WIDTH  result.
- zero_o  out  1  result_o == 0.
- overflow_o  out  1  signed overflow (add/sub only).
- illegal_o  out  1  unsupported control code.

Behaviour:
- Codes:
  - 0010 add
  - 0110 sub
  - 0001 and
  - 0000 or
  - 1101 nor
  - 0111 slt (signed)
  - any other code is illegal.
- Reset (async, any state): state=IDLE, in_ready_o=1, out_valid_o=0, result_o=0, zero_o=0, overflow_o=0, illegal_o=0. Slice counter=0, carry=0.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i at a clock edge, latch A, ctrl, and B' (B inverted for sub/slt, else B). Set carry=1 for sub/slt, else 0. Clear counter and result. Go to RUN.
- RUN:
  - in_ready_o=0. One slice per cycle, slice index = counter.
  - Add/sub/slt: SLICE-bit add of A slice + B' slice + carry; carry register updated.
  - and/or/nor: bitwise on A and original B.
  - The last slice also records carry into bit WIDTH-1 and carry out.
  - After slice NSLICE-1 is written, go to DONE.
- Finalisation, registered on the same edge as the transition to DONE:
  - overflow = carry_into_msb XOR carry_out, for add/sub only; 0 otherwise.
  - slt: result = {WIDTH-1 zeros, diff_msb XOR overflow}; overflow_o=0.
  - Illegal code: result=0, illegal_o=1, overflow_o=0.
  - zero_o = (final result == 0).
- DONE:
  - out_valid_o=1. All outputs are held stable until out_ready_i is sampled high.
  - Then return to IDLE: out_valid_o=0; result and flags hold their last values.
- Latency: request accepted at edge E; out_valid_o is high after edge E+NSLICE (4 cycles at defaults). Earliest next accept is the edge after out_valid_o/out_ready_i complete.
- Simultaneous events:
  - in_valid_i while not IDLE is ignored; in_ready_o is low, and the requester must hold.
  - out_ready_i outside DONE has no effect.
- Reset mid-RUN or mid-DONE: the operation is discarded, with no partial result visible.
- Arithmetic is modulo 2^WIDTH. The carry register spans exactly one bit between slices.

Decomposition:
- Package alu_ctrl_pkg holds:
  - the six ALU control code localparams, shared with the ALU control decoder;
  - FSM state encodings IDLE/RUN/DONE.
- One sub-module, alu_slice: combinational SLICE-bit slice. Inputs: a, b, b_inv, cin, ctrl. Outputs: y, cout, c_into_msb.

Test Plan (WIDTH=32, SLICE=8):
- add 0x7FFFFFFF + 0x00000001 -> out_valid_o 4 cycles after accept; result 0x80000000, overflow_o=1, zero_o=0.
- sub 0x00000005 - 0x00000005 -> result 0x00000000, zero_o=1, overflow_o=0. Also nor 0,0 -> 0xFFFFFFFF. Also and 0xF0F0F0F0, 0xFF00FF00 -> 0xF000F000.
- slt 0xFFFFFFFF vs 0x00000001 -> 1; slt 0x80000000 vs 0x00000001 -> 1 (overflow-corrected); slt 0x00000001 vs 0xFFFFFFFF -> 0; overflow_o=0 in all three.
- Backpressure: out_ready_i low for 3 cycles in DONE -> outputs constant, in_ready_o=0, a concurrent in_valid_i is not accepted. Raise out_ready_i -> IDLE next cycle, then accept.
- rst_i pulsed during RUN slice 2 -> out_valid_o=0 and result_o=0 immediately, in_ready_o=1. A fresh add 3+4 then yields 7.
- ctrl 1111 with src 0x12345678, 0x1 -> result 0, illegal_o=1, zero_o=1, overflow_o=0.
